enum_pair_tracker: RTL and testbench

- Sequential stage directly downstream of the enum-pair generator.
- Consumes its 128-bit word: two independent 64-bit halves, each packing two 32-bit enum fields {a,b}.
- Per half, checks that each pair is a legal rotation, tracks runs of consecutive rotating beats with a per-half FSM, and emits a registered 128-bit status word through a valid/ready handshake.
- Each half's FSM enum is declared inside its own `if (1)` generate scope, with identical literal names in both scopes, to exercise enum scoping.

---
 rtl/enum_pair_tracker.sv | 152 +++++++++++++++
 tb/tb_enum_pair_tracker.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/enum_pair_tracker.sv
// Enum-pair run tracker: checks each 64-bit half for legal {a,b} rotations,
// tracks rotating runs per half and emits a registered status word.
module enum_pair_tracker #(
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic        accept;
  logic [63:0] st0;
  logic [63:0] st1;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  function automatic logic [1:0] succ(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic legal(input logic [31:0] a, input logic [31:0] b);
    return (a <= 32'd2) && (b <= 32'd2) && (b[1:0] == succ(a[1:0]));
  endfunction

  if (1) begin : g_half0
    typedef enum logic [1:0] {IDLE = 2'd0, SEQ = 2'd1, BREAK = 2'd2, ERR = 2'd3} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;
    logic [31:0]      a, b;

    assign a = in[63:32];
    assign b = in[31:0];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      if (clr) begin
        state_d = IDLE;
        cnt_d   = '0;
        last_d  = '0;
      end else if (accept && state_q != ERR) begin
        if (!legal(a, b)) begin
          state_d = ERR;
        end else if (state_q == IDLE) begin
          state_d = SEQ;
          cnt_d   = CNT_W'(1);
          last_d  = a[1:0];
        end else if (a[1:0] == succ(last_q)) begin
          state_d = SEQ;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          last_d  = a[1:0];
        end else begin
          state_d = BREAK;
          cnt_d   = CNT_W'(1);
          last_d  = a[1:0];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        last_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        last_q  <= last_d;
      end
    end

    // Status is built from the post-update values so out reflects this beat.
    assign st0 = {32'(cnt_d), state_d, 28'd0, last_d};
  end

  if (1) begin : g_half1
    typedef enum logic [1:0] {IDLE = 2'd0, SEQ = 2'd1, BREAK = 2'd2, ERR = 2'd3} state_t;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       last_q, last_d;
    logic [31:0]      a, b;

    assign a = in[127:96];
    assign b = in[95:64];

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      if (clr) begin
        state_d = IDLE;
        cnt_d   = '0;
        last_d  = '0;
      end else if (accept && state_q != ERR) begin
        if (!legal(a, b)) begin
          state_d = ERR;
        end else if (state_q == IDLE) begin
          state_d = SEQ;
          cnt_d   = CNT_W'(1);
          last_d  = a[1:0];
        end else if (a[1:0] == succ(last_q)) begin
          state_d = SEQ;
          cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
          last_d  = a[1:0];
        end else begin
          state_d = BREAK;
          cnt_d   = CNT_W'(1);
          last_d  = a[1:0];
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        last_q  <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        last_q  <= last_d;
      end
    end

    assign st1 = {32'(cnt_d), state_d, 28'd0, last_d};
  end

  // A beat consumed under clr is discarded: out keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= '0;
      out_valid <= 1'b0;
    end else if (accept && !clr) begin
      out       <= {st1, st0};
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_enum_pair_tracker.sv
// Bench for enum_pair_tracker: directed vector table, corner sequences and
// randomized traffic against a rule-level model, on CNT_W=32 and CNT_W=2.
module tb_enum_pair_tracker;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] in_w = '0;
  logic         ir0, ir1, ov0, ov1;
  logic [127:0] o0, o1;

  always #5 clk = ~clk;

  enum_pair_tracker #(.CNT_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir0),
    .in(in_w), .out_valid(ov0), .out_ready(out_ready), .out(o0)
  );

  enum_pair_tracker #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(ir1),
    .in(in_w), .out_valid(ov1), .out_ready(out_ready), .out(o1)
  );

  int ncmp = 0;
  int nfail = 0;

  // Reference model: [dut][half]; states coded IDLE=0 SEQ=1 BREAK=2 ERR=3
  int              mst[2][2];
  longint unsigned mcnt[2][2];
  longint unsigned mlast[2][2];
  logic [127:0]    mout[2];
  logic            mval[2];
  longint unsigned mmax[2] = '{64'hFFFF_FFFF, 64'd3};

  typedef struct {
    int           a0, b0, a1, b1;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int h = 0; h < 2; h++) begin
        mst[d][h] = 0; mcnt[d][h] = 0; mlast[d][h] = 0;
      end
      mout[d] = '0;
      mval[d] = 1'b0;
    end
  endfunction

  function automatic void upd(input int d, input int h, input longint unsigned a,
                              input longint unsigned b);
    bit lg;
    lg = (a <= 2) && (b <= 2) && (b == (a + 1) % 3);
    if (mst[d][h] == 3) return;
    if (!lg) begin
      mst[d][h] = 3;
    end else if (mst[d][h] == 0) begin
      mst[d][h] = 1; mcnt[d][h] = 1; mlast[d][h] = a;
    end else if (a == (mlast[d][h] + 1) % 3) begin
      mst[d][h] = 1;
      if (mcnt[d][h] < mmax[d]) mcnt[d][h] = mcnt[d][h] + 1;
      mlast[d][h] = a;
    end else begin
      mst[d][h] = 2; mcnt[d][h] = 1; mlast[d][h] = a;
    end
  endfunction

  function automatic logic [63:0] mstatus(input int d, input int h);
    return {32'(mcnt[d][h]), 2'(mst[d][h]), 28'd0, 2'(mlast[d][h])};
  endfunction

  function automatic void model_edge();
    bit acc;
    for (int d = 0; d < 2; d++) begin
      acc = in_valid && (!mval[d] || out_ready);
      for (int h = 0; h < 2; h++) begin
        if (clr) begin
          mst[d][h] = 0; mcnt[d][h] = 0; mlast[d][h] = 0;
        end else if (acc) begin
          upd(d, h, longint'(in_w[64*h+32 +: 32]), longint'(in_w[64*h +: 32]));
        end
      end
      if (acc && !clr) begin
        mout[d] = {mstatus(d, 1), mstatus(d, 0)};
        mval[d] = 1'b1;
      end else if (out_ready) begin
        mval[d] = 1'b0;
      end
    end
  endfunction

  task automatic beat(input logic v, input logic r, input logic c,
                      input int a0, input int b0, input int a1, input int b1);
    in_valid = v; out_ready = r; clr = c;
    in_w = {32'(a1), 32'(b1), 32'(a0), 32'(b0)};
  endtask

  // Called at posedge+1; checks in_ready mid-cycle and outputs after the edge.
  task automatic step();
    #2;
    chk("in_ready32", ir0, !mval[0] || out_ready);
    chk("in_ready2", ir1, !mval[1] || out_ready);
    @(posedge clk);
    model_edge();
    #1;
    chk("out32", o0, mout[0]);
    chk("out_valid32", ov0, mval[0]);
    chk("out2", o1, mout[1]);
    chk("out_valid2", ov1, mval[1]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_out32", o0, '0);
    chk("rst_ov32", ov0, 1'b0);
    chk("rst_out2", o1, '0);
    chk("rst_ov2", ov1, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int prev[2];
    int a[2], b[2];

    tbl[0] = '{0, 1, 2, 0, {64'h00000001_40000002, 64'h00000001_40000000}};
    tbl[1] = '{1, 2, 0, 1, {64'h00000002_40000000, 64'h00000002_40000001}};
    tbl[2] = '{2, 0, 1, 1, {64'h00000002_C0000000, 64'h00000003_40000002}};
    tbl[3] = '{0, 1, 1, 2, {64'h00000002_C0000000, 64'h00000004_40000000}};
    tbl[4] = '{0, 1, 2, 0, {64'h00000002_C0000000, 64'h00000001_80000000}};
    tbl[5] = '{1, 2, 3, 1, {64'h00000002_C0000000, 64'h00000002_40000001}};
    tbl[6] = '{0, 2, 0, 1, {64'h00000002_C0000000, 64'h00000002_C0000001}};

    #2;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      beat(1'b1, 1'b1, 1'b0, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1);
      step();
      chk($sformatf("vec%0d", i), o0, tbl[i].exp);
    end

    // clr with no beat: trackers reset, out keeps last word
    beat(1'b0, 1'b1, 1'b1, 0, 0, 0, 0);
    step();
    chk("clr_hold_out", o0, tbl[6].exp);
    beat(1'b1, 1'b1, 1'b0, 0, 1, 0, 1);
    step();
    chk("after_clr", o0, {64'h00000001_40000000, 64'h00000001_40000000});

    // backpressure: three stalled cycles, then release
    beat(1'b1, 1'b0, 1'b0, 1, 2, 1, 2);
    repeat (3) begin
      step();
      chk("stall_ready", ir0, 1'b0);
      chk("stall_out", o0, {64'h00000001_40000000, 64'h00000001_40000000});
    end
    out_ready = 1'b1;
    step();
    chk("release", o0, {64'h00000002_40000001, 64'h00000002_40000001});

    // clr coincident with accepted beat: beat discarded, trackers IDLE
    beat(1'b1, 1'b1, 1'b1, 2, 0, 2, 0);
    step();
    chk("clr_beat_out", o0, {64'h00000002_40000001, 64'h00000002_40000001});
    beat(1'b1, 1'b1, 1'b0, 0, 1, 0, 1);
    step();
    chk("clr_beat_idle", o0, {64'h00000001_40000000, 64'h00000001_40000000});

    // saturation on the CNT_W=2 instance
    do_reset();
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 1'b1, 1'b0, i % 3, (i + 1) % 3, i % 3, (i + 1) % 3);
      step();
    end
    chk("sat_cnt2", o1[63:32], 32'd3);
    chk("sat_state2", o1[31:30], 2'd1);
    chk("cnt32", o0[63:32], 32'd5);

    // async reset mid-stream (out_valid is high here)
    chk("pre_rst_valid", ov0, 1'b1);
    do_reset();

    prev[0] = 0; prev[1] = 0;
    for (int n = 0; n < 800; n++) begin
      for (int h = 0; h < 2; h++) begin
        if ($urandom_range(0, 15) == 0) a[h] = int'($urandom() | 32'h4);
        else if ($urandom_range(0, 1) == 0) a[h] = (prev[h] + 1) % 3;
        else a[h] = int'($urandom_range(0, 2));
        if ($urandom_range(0, 9) == 0) b[h] = int'($urandom_range(0, 3));
        else b[h] = (a[h] >= 0 && a[h] <= 2) ? (a[h] + 1) % 3 : 0;
        if (a[h] >= 0 && a[h] <= 2) prev[h] = a[h];
      end
      beat($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 31) == 0, a[0], b[0], a[1], b[1]);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
